// File: rtl/ct_ifu_refill_pkg.sv
// Shared definitions for the icache refill predecoder: FSM encoding,
// RISC-V control-flow opcodes and predecode nibble bit positions.
package ct_ifu_refill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam int PD_START = 3;
    localparam int PD_S32   = 2;
    localparam int PD_BR    = 1;
    localparam int PD_JMP   = 0;

    localparam int HW_PER_BEAT = 8;

endpackage

// File: rtl/ct_ifu_predecd_hw.sv
// Predecode of one 16-bit parcel. cont marks the parcel as the upper half
// of a 32-bit instruction that started in the previous parcel.
module ct_ifu_predecd_hw
    import ct_ifu_refill_pkg::*;
(
    input  logic [15:0] hw,
    input  logic        cont,
    output logic [3:0]  nib,
    output logic        start32
);

    logic start;
    logic is_br32;
    logic is_br16;
    logic is_jmp32;
    logic is_cj;
    logic is_cjr;
    logic unused_hw12;

    // c.jr and c.jalr differ only in bit 12 and both count as jumps.
    assign unused_hw12 = hw[12];

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        nib      = 4'b0000;
        start    = ~cont;
        start32  = start & (hw[1:0] == 2'b11);
        is_br32  = (hw[6:0] == OPC_BRANCH);
        is_br16  = (hw[1:0] == 2'b01) && (hw[15:14] == 2'b11);
        is_jmp32 = (hw[6:0] == OPC_JAL) || (hw[6:0] == OPC_JALR);
        is_cj    = (hw[1:0] == 2'b01) && (hw[15:13] == 3'b101);
        is_cjr   = (hw[1:0] == 2'b10) && (hw[15:13] == 3'b100) &&
                   (hw[6:2] == 5'd0) && (hw[11:7] != 5'd0);

        nib[PD_START] = start;
        nib[PD_S32]   = start32;
        nib[PD_BR]    = start & (is_br32 | is_br16);
        nib[PD_JMP]   = start & (is_jmp32 | is_cj | is_cjr);
    end

endmodule

// File: rtl/ct_ifu_icache_refill_predecd.sv
// Refill-side predecoder: predecodes 128-bit L2 refill beats and writes the
// 32-bit predecode word of each beat into icache predecode array 0.
module ct_ifu_icache_refill_predecd
    import ct_ifu_refill_pkg::*;
#(
    parameter int LINE_BEATS = 4,
    parameter int IDX_W      = 16
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst_b,
    input  logic             refill_start_vld,
    input  logic [IDX_W-1:0] refill_start_index,
    input  logic             l2_refill_data_vld,
    input  logic [127:0]     l2_refill_data,
    input  logic             l2_refill_data_err,
    output logic             ifu_l2_refill_rdy,
    input  logic             icache_wr_grant,
    output logic             ifu_icache_predecd_array0_clk_en,
    output logic             ifu_icache_predecd_array0_cen_b,
    output logic             ifu_icache_predecd_array0_wen_b,
    output logic [IDX_W-1:0] ifu_icache_index,
    output logic [31:0]      ifu_icache_predecd_array0_din,
    output logic             refill_done,
    output logic             refill_err
);

    localparam int LB   = $clog2(LINE_BEATS);
    localparam int HI_W = IDX_W - LB - 3;
    localparam logic [LB:0] BEATS_C = (LB + 1)'(LINE_BEATS);

    state_e state_q, state_d;

    logic             out_vld_q, out_vld_d;
    logic             carry_q, carry_d;
    logic             err_sticky_q, err_sticky_d;
    logic [LB:0]      acc_cnt_q, acc_cnt_d;
    logic [HI_W-1:0]  base_hi_q, base_hi_d;
    logic [31:0]      din_q, din_d;
    logic [IDX_W-1:0] index_q, index_d;

    logic rdy;
    logic acc;
    logic wr;
    logic last_wr;

    logic [31:0]          pd_din;
    logic [HW_PER_BEAT:0] chain;
    logic                 unused_idx_lo;

    // The line offset bits of the start index are replaced by the beat counter.
    assign unused_idx_lo = ^refill_start_index[LB+2:0];

    assign chain[0] = carry_q;

    for (genvar h = 0; h < HW_PER_BEAT; h++) begin : g_pd
        ct_ifu_predecd_hw u_hw (
            .hw      (l2_refill_data[16*h +: 16]),
            .cont    (chain[h]),
            .nib     (pd_din[4*h +: 4]),
            .start32 (chain[h+1])
        );
    end

    always_comb begin
        rdy     = (state_q == ST_FILL) && (!out_vld_q || icache_wr_grant) &&
                  (acc_cnt_q < BEATS_C);
        acc     = l2_refill_data_vld && rdy;
        wr      = out_vld_q && icache_wr_grant;
        last_wr = wr && (&index_q[LB+2:3]);
    end

    // FSM: state register.
    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (refill_start_vld) state_d = ST_FILL;
            ST_FILL: if (last_wr)          state_d = ST_DONE;
            ST_DONE:                       state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs. The array write is combinational on grant so it lands in the granted cycle.
    always_comb begin
        refill_done                      = (state_q == ST_DONE);
        refill_err                       = (state_q == ST_DONE) && err_sticky_q;
        ifu_l2_refill_rdy                = rdy;
        ifu_icache_predecd_array0_cen_b  = ~wr;
        ifu_icache_predecd_array0_wen_b  = ~wr;
        ifu_icache_predecd_array0_clk_en = out_vld_q | acc;
        ifu_icache_index                 = index_q;
        ifu_icache_predecd_array0_din    = din_q;
    end

    // Datapath: line setup on start, output stage load on accept, drain on write.
    always_comb begin
        out_vld_d    = out_vld_q;
        carry_d      = carry_q;
        err_sticky_d = err_sticky_q;
        acc_cnt_d    = acc_cnt_q;
        base_hi_d    = base_hi_q;
        din_d        = din_q;
        index_d      = index_q;

        if ((state_q == ST_IDLE) && refill_start_vld) begin
            base_hi_d    = refill_start_index[IDX_W-1:LB+3];
            acc_cnt_d    = '0;
            carry_d      = 1'b0;
            err_sticky_d = 1'b0;
        end

        if (wr) begin
            out_vld_d = 1'b0;
        end

        if (acc) begin
            out_vld_d    = 1'b1;
            din_d        = l2_refill_data_err ? 32'h0 : pd_din;
            index_d      = {base_hi_q, acc_cnt_q[LB-1:0], 3'b000};
            carry_d      = chain[HW_PER_BEAT];
            acc_cnt_d    = acc_cnt_q + (LB + 1)'(1);
            err_sticky_d = err_sticky_q | l2_refill_data_err;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            out_vld_q    <= 1'b0;
            carry_q      <= 1'b0;
            err_sticky_q <= 1'b0;
            acc_cnt_q    <= '0;
            base_hi_q    <= '0;
            din_q        <= '0;
            index_q      <= '0;
        end else begin
            out_vld_q    <= out_vld_d;
            carry_q      <= carry_d;
            err_sticky_q <= err_sticky_d;
            acc_cnt_q    <= acc_cnt_d;
            base_hi_q    <= base_hi_d;
            din_q        <= din_d;
            index_q      <= index_d;
        end
    end

endmodule
